// File: rtl/la_pkg.sv
// la_pkg: shared state and trigger-mode encodings for the capture engine
package la_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_e;
  localparam logic [2:0] TRIG_IMM  = 3'd0;
  localparam logic [2:0] TRIG_RISE = 3'd1;
  localparam logic [2:0] TRIG_FALL = 3'd2;
  localparam logic [2:0] TRIG_ANY  = 3'd3;
  localparam logic [2:0] TRIG_PAT  = 3'd4;
  // Reserved modes behave as immediate
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return m > TRIG_PAT ? TRIG_IMM : m;
  endfunction
endpackage

// File: rtl/la_capture_core_if.sv
// la_capture_core_if: sampling, trigger configuration and readout signals of the capture engine
interface la_capture_core_if #(
  parameter int CH_W       = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int DIV_W      = 16
);
  logic [CH_W-1:0]       data_in;
  logic                  arm;
  logic                  abort;
  logic [DIV_W-1:0]      div_sel;
  logic [2:0]            trig_mode;
  logic [CH_W-1:0]       trig_mask;
  logic [CH_W-1:0]       trig_value;
  logic [DEPTH_LOG2-1:0] pre_cnt;
  logic                  rd_en;
  logic                  rd_valid;
  logic [CH_W-1:0]       rd_data;
  logic                  rd_last;
  logic [2:0]            state_o;
  logic                  done;
  logic [DEPTH_LOG2-1:0] trig_addr;
  modport master (
    output data_in, arm, abort, div_sel, trig_mode, trig_mask, trig_value, pre_cnt, rd_en,
    input  rd_valid, rd_data, rd_last, state_o, done, trig_addr
  );
  modport slave (
    input  data_in, arm, abort, div_sel, trig_mode, trig_mask, trig_value, pre_cnt, rd_en,
    output rd_valid, rd_data, rd_last, state_o, done, trig_addr
  );
endinterface

// File: rtl/la_sample_ram.sv
// la_sample_ram: simple dual-port sample buffer with synchronous write and registered read
module la_sample_ram #(
  parameter int W  = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [1<<AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/la_capture_core.sv
// la_capture_core: triggered logic-analyser capture into a circular buffer with chronological readout
module la_capture_core
  import la_pkg::*;
#(
  parameter int CH_W       = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int DIV_W      = 16
) (
  input logic              clk,
  input logic              rst,
  la_capture_core_if.slave bus
);
  typedef logic [DEPTH_LOG2-1:0] addr_t;
  localparam addr_t ONE = addr_t'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LAST = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);
  state_e state_q, state_d;
  logic [DIV_W-1:0] div_q, div_cnt_q;
  logic [2:0] mode_q;
  logic [CH_W-1:0] mask_q, value_q, prev_q, ram_q;
  logic have_prev_q, rd_valid_q, rd_last_q;
  addr_t pre_q, wr_ptr_q, cnt_q, rd_ptr_q, trig_addr_q, post_n;
  logic [DEPTH_LOG2:0] rd_cnt_q;
  logic start, active, tick, rise, fall, match, hit, pre_done, post_done, rd_issue;
  assign start = bus.arm && !bus.abort && (state_q == IDLE || state_q == DONE);
  assign active = state_q inside {PRE, WAIT_TRIG, POST};
  assign tick = active && div_cnt_q == div_q;
  assign post_n = ~pre_q;
  assign rise = have_prev_q && |(~prev_q & bus.data_in & mask_q);
  assign fall = have_prev_q && |(prev_q & ~bus.data_in & mask_q);
  assign match = mode_q == TRIG_RISE ? rise :
                 mode_q == TRIG_FALL ? fall :
                 mode_q == TRIG_ANY  ? rise | fall :
                 mode_q == TRIG_PAT  ? ((bus.data_in ^ value_q) & mask_q) == '0 : 1'b1;
  assign hit = tick && state_q == WAIT_TRIG && match;
  assign pre_done = tick && state_q == PRE && cnt_q == pre_q - ONE;
  assign post_done = tick && state_q == POST && cnt_q == post_n - ONE;
  assign rd_issue = state_q == DONE && bus.rd_en && !rd_cnt_q[DEPTH_LOG2] && !bus.abort && !start;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (bus.abort) state_d = IDLE;
    else if (start) state_d = bus.pre_cnt == '0 ? WAIT_TRIG : PRE;
    else if (pre_done) state_d = WAIT_TRIG;
    else if (hit) state_d = post_n == '0 ? DONE : POST;
    else if (post_done) state_d = DONE;
    else if (state_q == DONE && rd_last_q) state_d = IDLE;
  end
  always_comb begin
    bus.state_o = state_q;
    bus.done = state_q == DONE;
    bus.rd_valid = rd_valid_q;
    bus.rd_last = rd_last_q;
    bus.rd_data = rd_valid_q ? ram_q : '0;
    bus.trig_addr = trig_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      div_cnt_q <= '0;
      mode_q <= TRIG_IMM;
      mask_q <= '0;
      value_q <= '0;
      pre_q <= '0;
      prev_q <= '0;
      have_prev_q <= 1'b0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      rd_ptr_q <= '0;
      trig_addr_q <= '0;
      rd_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_last_q <= rd_issue && rd_cnt_q == LAST;
      if (start) begin
        div_q <= bus.div_sel;
        mode_q <= norm_mode(bus.trig_mode);
        mask_q <= bus.trig_mask;
        value_q <= bus.trig_value;
        pre_q <= bus.pre_cnt;
        div_cnt_q <= '0;
        have_prev_q <= 1'b0;
        wr_ptr_q <= '0;
        cnt_q <= '0;
        rd_cnt_q <= '0;
      end else begin
        if (active) div_cnt_q <= tick ? '0 : div_cnt_q + DIV_ONE;
        if (tick) begin
          wr_ptr_q <= wr_ptr_q + ONE;
          prev_q <= bus.data_in;
          have_prev_q <= 1'b1;
        end
        if (pre_done || hit) cnt_q <= '0;
        else if (tick && state_q != WAIT_TRIG) cnt_q <= cnt_q + ONE;
        // Readout begins pre_q samples before the trigger, wrapping mod DEPTH
        if (hit) begin
          trig_addr_q <= wr_ptr_q;
          rd_ptr_q <= wr_ptr_q - pre_q;
        end else if (rd_issue) begin
          rd_ptr_q <= rd_ptr_q + ONE;
          rd_cnt_q <= rd_cnt_q + CNT_ONE;
        end
      end
    end
  end
  la_sample_ram #(.W(CH_W), .AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (tick),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_q)
  );
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: randomized capture scenarios checked against a tick-level sample-history model
module tb_la_capture_core;
  localparam int CH_W = 8;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  la_capture_core_if #(.CH_W(CH_W), .DEPTH_LOG2(DL), .DIV_W(DIV_W)) bus ();
  la_capture_core #(.CH_W(CH_W), .DEPTH_LOG2(DL), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  int checks = 0;
  int errors = 0;
  logic [7:0] s[$];
  int t_idx;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int mode, input logic [7:0] mask, input logic [7:0] value,
                              input logic [7:0] cur, input logic [7:0] prev, input bit has_prev);
    bit r = 1'b0;
    bit f = 1'b0;
    bit m = 1'b1;
    for (int i = 0; i < 8; i++)
      if (mask[i]) begin
        if (has_prev && !prev[i] && cur[i]) r = 1'b1;
        if (has_prev && prev[i] && !cur[i]) f = 1'b1;
        if (cur[i] !== value[i]) m = 1'b0;
      end
    return mode == 1 ? r : mode == 2 ? f : mode == 3 ? (r | f) : mode == 4 ? m : 1'b1;
  endfunction

  function automatic logic [7:0] gen(input int kind, input int c, input int div, input int k);
    logic [7:0] r = 8'($urandom);
    bit tk = (c % (div + 1)) == div;
    case (kind)
      0: return 8'(c + 8'h30);
      1: return {r[7:1], c >= k};
      2: begin
        if (c >= k) return {4'hA, r[3:0]};
        if (tk && r[7:4] == 4'hA) r[7:4] = 4'h5;
        return r;
      end
      3: return (c % 2) == 1 ? 8'hFF : 8'h00;
      default: begin
        if (c >= k) return 8'h5A;
        return r == 8'h5A ? 8'hA5 : r;
      end
    endcase
  endfunction

  task automatic run_capture(input int mode, input logic [7:0] mask, input logic [7:0] value,
                             input int pre, input int div, input int kind, input int k, input bit arm_post);
    int c = 0;
    int phase;
    bit fin = 1'b0;
    logic [7:0] d;
    s.delete();
    t_idx = -1;
    bus.trig_mode = 3'(mode);
    bus.trig_mask = mask;
    bus.trig_value = value;
    bus.pre_cnt = 4'(pre);
    bus.div_sel = 16'(div);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    while (!fin) begin
      d = gen(kind, c, div, k);
      bus.data_in = d;
      bus.rd_en = 1'($urandom);
      bus.arm = arm_post && t_idx >= 0;
      bus.trig_mode = 3'($urandom);
      bus.trig_mask = 8'($urandom);
      bus.trig_value = 8'($urandom);
      bus.pre_cnt = 4'($urandom);
      bus.div_sel = 16'($urandom_range(0, 3));
      step();
      if (c % (div + 1) == div) begin
        s.push_back(d);
        if (t_idx < 0 && s.size() - 1 >= pre &&
            cond(mode, mask, value, d, s.size() > 1 ? s[s.size()-2] : 8'h00, s.size() > 1))
          t_idx = s.size() - 1;
      end
      c++;
      fin = t_idx >= 0 && s.size() == t_idx + DEPTH - pre;
      phase = s.size() < pre ? 1 : t_idx < 0 ? 2 : fin ? 4 : 3;
      checks++;
      if (bus.state_o !== 3'(phase)) begin
        errors++;
        $display("FAIL capture_state cycle %0d got %0d want %0d", c, bus.state_o, phase);
      end
      checks++;
      if (bus.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_valid_before_done cycle %0d got %0b want 0", c, bus.rd_valid);
      end
      if (c > 3000) begin
        checks++;
        errors++;
        $display("FAIL capture_timeout got no DONE within 3000 cycles want DONE");
        fin = 1'b1;
      end
    end
    bus.arm = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_flag got %0b want 1", bus.done);
    end
    checks++;
    if (bus.trig_addr !== 4'(t_idx)) begin
      errors++;
      $display("FAIL trig_addr got %0d want %0d", bus.trig_addr, t_idx % DEPTH);
    end
  endtask

  task automatic do_readout(input int pre, input int nwords);
    int n = 0;
    int cyc = 0;
    while (n < nwords && cyc < 300) begin
      bus.rd_en = ($urandom % 4) != 0;
      step();
      cyc++;
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (bus.rd_data !== s[t_idx-pre+n]) begin
          errors++;
          $display("FAIL rd_data word %0d got %02h want %02h", n, bus.rd_data, s[t_idx-pre+n]);
        end
        checks++;
        if (bus.rd_last !== (n == DEPTH - 1)) begin
          errors++;
          $display("FAIL rd_last word %0d got %0b want %0b", n, bus.rd_last, n == DEPTH - 1);
        end
        n++;
      end
    end
    bus.rd_en = 1'b0;
    checks++;
    if (n < nwords) begin
      errors++;
      $display("FAIL readout_timeout got %0d words want %0d", n, nwords);
    end
    if (nwords == DEPTH) begin
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      checks++;
      if (bus.state_o !== 3'd0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_last got state %0d done %0b valid %0b want 0 0 0",
                 bus.state_o, bus.done, bus.rd_valid);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.state_o, bus.done, bus.rd_valid, bus.rd_data, bus.rd_last, bus.trig_addr} !== '0) begin
      errors++;
      $display("FAIL %s got state %0d done %0b valid %0b data %02h last %0b taddr %0d want all 0",
               name, bus.state_o, bus.done, bus.rd_valid, bus.rd_data, bus.rd_last, bus.trig_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++;
      $display("FAIL idle_rd_en got valid %0b state %0d want 0 0", bus.rd_valid, bus.state_o);
    end
  endtask

  task automatic test_immediate();
    run_capture(0, 8'h00, 8'h00, 0, 0, 0, 0, 1'b0);
    do_readout(0, DEPTH);
  endtask

  task automatic test_rising();
    run_capture(1, 8'h01, 8'h00, 4, 0, 1, $urandom_range(6, 25), 1'b0);
    do_readout(4, DEPTH);
  endtask

  task automatic test_pattern_div();
    run_capture(4, 8'hF0, 8'hA0, 3, 2, 2, $urandom_range(12, 40), 1'b0);
    do_readout(3, DEPTH);
  endtask

  task automatic test_edge_mask_zero();
    bus.trig_mode = 3'd3;
    bus.trig_mask = 8'h00;
    bus.pre_cnt = 4'd0;
    bus.div_sel = 16'd0;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.data_in = (i % 2) == 1 ? 8'hFF : 8'h00;
      step();
      checks++;
      if (bus.state_o !== 3'd2) begin
        errors++;
        $display("FAIL mask_zero_wait cycle %0d got %0d want 2", i, bus.state_o);
      end
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.state_o !== 3'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort got state %0d done %0b want 0 0", bus.state_o, bus.done);
    end
  endtask

  task automatic test_abort_arm();
    bus.trig_mode = 3'd3;
    bus.trig_mask = 8'h00;
    bus.pre_cnt = 4'd2;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    step();
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    step();
    checks++;
    if (bus.state_o !== 3'd0) begin
      errors++;
      $display("FAIL abort_arm_busy got %0d want 0", bus.state_o);
    end
    step();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.state_o !== 3'd0) begin
      errors++;
      $display("FAIL abort_arm_idle got %0d want 0", bus.state_o);
    end
  endtask

  task automatic test_pre_clamp();
    run_capture(4, 8'hFF, 8'h5A, 15, 0, 4, 20, 1'b0);
    do_readout(15, DEPTH);
  endtask

  task automatic test_arm_in_post();
    run_capture(2, 8'h80, 8'h00, 6, 1, 0, 0, 1'b1);
    do_readout(6, DEPTH);
  endtask

  task automatic test_wrap();
    run_capture(4, 8'hFF, 8'h5A, 8, 0, 4, 48, 1'b0);
    do_readout(8, DEPTH);
  endtask

  task automatic test_back_to_back();
    run_capture(3, 8'h0F, 8'h00, 2, 1, 1, 10, 1'b0);
    run_capture(0, 8'h00, 8'h00, 5, 3, 0, 0, 1'b0);
    do_readout(5, DEPTH);
  endtask

  task automatic test_rst_readout();
    run_capture(1, 8'h01, 8'h00, 4, 0, 1, 9, 1'b0);
    do_readout(4, 5);
    bus.rd_en = 1'b1;
    rst = 1'b1;
    step();
    check_all_zero("rst_mid_readout");
    rst = 1'b0;
    bus.rd_en = 1'b0;
    step();
  endtask

  initial begin
    bus.data_in = '0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.div_sel = '0;
    bus.trig_mode = '0;
    bus.trig_mask = '0;
    bus.trig_value = '0;
    bus.pre_cnt = '0;
    bus.rd_en = 1'b0;
    test_reset();
    test_immediate();
    test_rising();
    test_pattern_div();
    test_edge_mask_zero();
    test_abort_arm();
    test_pre_clamp();
    test_arm_in_post();
    test_wrap();
    test_back_to_back();
    test_rst_readout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
